alu_mc: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_muldiv.sv | 84 ++++++++
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SHL   = 4'd2,
    OP_SHR   = 4'd3,
    OP_PASS  = 4'd4,
    OP_LDLO  = 4'd5,
    OP_LDHI  = 4'd6,
    OP_CMPEQ = 4'd7,
    OP_CMPLT = 4'd8,
    OP_CMPGT = 4'd9,
    OP_MULU  = 4'd10,
    OP_DIVU  = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  localparam int NFLAGS   = 5;
  localparam int FLAG_Z   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_CMP = 3;
  localparam int FLAG_ERR = 4;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// {hi, lo} is a single shift register shared by both operations.
module alu_muldiv #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  logic          busy_q;
  logic          div_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  opnd;

  logic [W:0]    mul_sum;
  logic [W:0]    div_t;
  logic          div_ge;
  logic [W-1:0]  div_diff;
  logic [W-1:0]  hi_n;
  logic [W-1:0]  lo_n;

  // Multiply shifts right (multiplier bits leave lo), divide shifts left
  // (quotient bits enter lo); opnd is the multiplicand or the divisor.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : '0);
    div_t    = {hi_q, lo_q[W-1]};
    div_ge   = (div_t >= {1'b0, opnd});
    div_diff = div_t[W-1:0] - opnd;
    hi_n     = '0;
    lo_n     = '0;
    if (div_q) begin
      hi_n = div_ge ? div_diff : div_t[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end else begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd   <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= is_div ? a : b;
      opnd   <= is_div ? b : a;
    end else if (busy_q) begin
      if (cnt == CNT_LAST) begin
        busy_q <= 1'b0;
      end else begin
        hi_q <= hi_n;
        lo_q <= lo_n;
        cnt  <= cnt + 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CNT_LAST);
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle unit, iterative mul/div, result FSM
// and valid/ready handshakes on both ports.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [W/2-1:0]    imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      result,
  output logic [W-1:0]      result_hi,
  output logic [NFLAGS-1:0] flags,
  output alu_state_t        dbg_state
);

  localparam logic [W-1:0] W_LIM = W'(W);

  alu_state_t        state;
  logic              accept;
  logic              is_div_op;
  logic              go_multi;
  logic              md_start;
  logic              md_busy;
  logic              md_done;
  logic [W-1:0]      md_lo;
  logic [W-1:0]      md_hi;
  logic [NFLAGS-1:0] md_flags;

  logic [W:0]        add_s;
  logic [W:0]        sub_s;
  logic [W-1:0]      sc_res;
  logic [W-1:0]      sc_hi;
  logic [NFLAGS-1:0] sc_flags;

  // A transfer happens on a rising edge where valid & ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.
  assign in_ready  = ((state == ST_IDLE) | ((state == ST_DONE) & out_ready)) & ~md_busy;
  assign accept    = in_valid & in_ready;
  assign is_div_op = (op == OP_DIVU);
  assign go_multi  = is_multicycle(op) & ~(is_div_op & (b == '0));
  assign md_start  = accept & go_multi;
  assign dbg_state = state;

  alu_muldiv #(.W(W)) u_muldiv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (md_start),
    .is_div  (is_div_op),
    .a       (a),
    .b       (b),
    .busy    (md_busy),
    .done    (md_done),
    .lo      (md_lo),
    .hi      (md_hi)
  );

  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_flags = '0;
    case (op)
      OP_ADD: begin
        sc_res           = add_s[W-1:0];
        sc_flags[FLAG_C] = add_s[W];
        sc_flags[FLAG_V] = (a[W-1] == b[W-1]) & (add_s[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_res           = sub_s[W-1:0];
        sc_flags[FLAG_C] = sub_s[W];
        sc_flags[FLAG_V] = (a[W-1] != b[W-1]) & (sub_s[W-1] != a[W-1]);
      end
      OP_SHL:   sc_res = (b >= W_LIM) ? '0 : (a << b[SW-1:0]);
      OP_SHR:   sc_res = (b >= W_LIM) ? '0 : (a >> b[SW-1:0]);
      OP_PASS:  sc_res = a;
      OP_LDLO:  sc_res = {a[W-1:W/2], imm};
      OP_LDHI:  sc_res = {imm, a[W/2-1:0]};
      OP_CMPEQ: sc_flags[FLAG_CMP] = (a == b);
      OP_CMPLT: sc_flags[FLAG_CMP] = (a < b);
      OP_CMPGT: sc_flags[FLAG_CMP] = (a > b);
      OP_MULU: ;
      // Only reaches the output registers for a zero divisor.
      OP_DIVU: begin
        sc_res             = '1;
        sc_hi              = a;
        sc_flags[FLAG_ERR] = 1'b1;
      end
      default:  sc_flags[FLAG_ERR] = 1'b1;
    endcase
    sc_flags[FLAG_Z] = (sc_res == '0);
  end

  always_comb begin
    md_flags         = '0;
    md_flags[FLAG_Z] = (md_lo == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (accept) begin
      if (go_multi) begin
        state     <= ST_BUSY;
        out_valid <= 1'b0;
      end else begin
        state     <= ST_DONE;
        out_valid <= 1'b1;
        result    <= sc_res;
        result_hi <= sc_hi;
        flags     <= sc_flags;
      end
    end else begin
      case (state)
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= md_lo;
            result_hi <= md_hi;
            flags     <= md_flags;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc with a reference model feeding an
// expected-result queue that is drained whenever a result is transferred.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + NFLAGS;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [3:0]        op = '0;
  logic [W-1:0]      a = '0;
  logic [W-1:0]      b = '0;
  logic [W/2-1:0]    imm = '0;
  logic              in_ready;
  logic              out_valid;
  logic [W-1:0]      result;
  logic [W-1:0]      result_hi;
  logic [NFLAGS-1:0] flags;
  alu_state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [EW-1:0] exp_q[$];

  alu_mc #(.W(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model, returns {flags, result_hi, result}.
  function automatic logic [EW-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W/2-1:0] im);
    logic [W-1:0]   r;
    logic [W-1:0]   h;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic           z, c, v, cmp, err;
    r = '0; h = '0; c = 1'b0; v = 1'b0; cmp = 1'b0; err = 1'b0;
    case (o)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_SUB: begin
        r = x - y;
        c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      OP_SHL:   r = (y >= 32'(W)) ? '0 : (x << y);
      OP_SHR:   r = (y >= 32'(W)) ? '0 : (x >> y);
      OP_PASS:  r = x;
      OP_LDLO:  r = {x[W-1:W/2], im};
      OP_LDHI:  r = {im, x[W/2-1:0]};
      OP_CMPEQ: cmp = (x == y);
      OP_CMPLT: cmp = (x < y);
      OP_CMPGT: cmp = (x > y);
      OP_MULU: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p[W-1:0];
        h = p[2*W-1:W];
      end
      OP_DIVU: begin
        if (y == '0) begin
          r = '1; h = x; err = 1'b1;
        end else begin
          r = x / y; h = x % y;
        end
      end
      default: err = 1'b1;
    endcase
    z = (r == '0);
    return {err, cmp, v, c, z, h, r};
  endfunction

  task automatic chk_w(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  // Driver: call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W/2-1:0] im, input bit track);
    int n;
    op = o; a = x; b = y; imm = im; in_valid = 1'b1;
    @(negedge clock);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk_i("accept_timeout", int'(n < 200), 1);
    if (track) exp_q.push_back(model(o, x, y, im));
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; imm = 16'($urandom);
  endtask

  // Scoreboard: compare every transferred result against the queue head.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      chk_i("q_nonempty", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk_w("result", {flags, result_hi, result}, exp_q.pop_front());
    end
  end

  initial begin
    int bad;
    int first;
    int n;
    logic [EW-1:0] snap;
    logic [W-1:0] y;

    repeat (3) @(negedge clock);
    chk_i("rst_out_valid", int'(out_valid), 0);
    chk_w("rst_regs", {flags, result_hi, result}, '0);
    chk_i("rst_state", int'(dbg_state), int'(ST_IDLE));
    reset_n = 1'b1;
    @(negedge clock);
    chk_i("rst_in_ready", int'(in_ready), 1);

    align();
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 16'h0, 1'b1);
    @(negedge clock);
    chk_i("add_latency", int'(out_valid), 1);
    align();
    send(OP_SUB, 32'h8000_0000, 32'h1, 16'h0, 1'b1);
    send(OP_SHL, 32'h1, 32'd32, 16'h0, 1'b1);
    send(OP_LDHI, 32'h1234_5678, 32'h0, 16'hABCD, 1'b1);
    send(OP_LDLO, 32'h1234_5678, 32'h0, 16'hABCD, 1'b1);
    send(OP_CMPLT, 32'd3, 32'd5, 16'h0, 1'b1);
    send(OP_CMPEQ, 32'd9, 32'd9, 16'h0, 1'b1);
    send(OP_SHR, 32'hF000_0000, 32'd31, 16'h0, 1'b1);

    // multiply latency and in_ready low while busy
    send(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 1'b1);
    bad = 0;
    repeat (W + 1) begin
      @(negedge clock);
      if (out_valid || in_ready) bad++;
    end
    chk_i("mul_busy_ready", bad, 0);
    @(negedge clock);
    chk_i("mul_latency", int'(out_valid), 1);
    chk_i("mul_cycles", cyc - acc_cyc, W + 1);

    align();
    send(OP_DIVU, 32'd100, 32'd7, 16'h0, 1'b1);
    send(OP_DIVU, 32'd5, 32'd0, 16'h0, 1'b1);
    @(negedge clock);
    chk_i("div0_latency", int'(out_valid), 1);
    align();
    send(4'd13, 32'h55, 32'h66, 16'h0, 1'b1);

    // back-to-back throughput
    send(OP_ADD, 32'd10, 32'd20, 16'h0, 1'b1);
    first = acc_cyc;
    send(OP_PASS, 32'hCAFE_F00D, 32'h0, 16'h0, 1'b1);
    send(OP_CMPGT, 32'd7, 32'd2, 16'h0, 1'b1);
    chk_i("b2b_throughput", acc_cyc - first, 2);

    // output stall with a new op offered
    align();
    out_ready = 1'b0;
    send(OP_PASS, 32'hDEAD_BEEF, 32'h0, 16'h0, 1'b1);
    op = OP_ADD; a = 32'd1; b = 32'd2; imm = '0; in_valid = 1'b1;
    @(negedge clock);
    snap = {flags, result_hi, result};
    chk_w("hold_value", snap, model(OP_PASS, 32'hDEAD_BEEF, 32'h0, 16'h0));
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (in_ready || !out_valid || ({flags, result_hi, result} !== snap)) bad++;
    end
    chk_i("hold_stable", bad, 0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(model(OP_ADD, 32'd1, 32'd2, 16'h0));
    @(negedge clock);
    chk_i("same_cycle_ready", int'(in_ready), 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk_i("post_stall_valid", int'(out_valid), 1);

    // reset abort in the middle of a multiply
    align();
    send(OP_MULU, 32'h1234, 32'h5678, 16'h0, 1'b0);
    repeat (10) @(negedge clock);
    chk_i("mid_busy_state", int'(dbg_state), int'(ST_BUSY));
    reset_n = 1'b0;
    #1;
    chk_i("abort_out_valid", int'(out_valid), 0);
    chk_i("abort_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_i("abort_in_ready", int'(in_ready), 1);
    bad = 0;
    repeat (W + 10) begin
      @(negedge clock);
      if (out_valid) bad++;
    end
    chk_i("abort_no_stale", bad, 0);

    // random mix including illegal opcodes, zero divisors and wide shifts
    align();
    for (int i = 0; i < 24; i++) begin
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send(4'($urandom_range(0, 15)), $urandom, y, 16'($urandom), 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk_i("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
